// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-keeping, alarm and stopwatch modes.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W      = 6;
  localparam int unsigned BCD_W        = 4;
  localparam int unsigned ONES_MAX     = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned HR24_MAX     = 23;

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD 00-59 counter; wrap_c flags the 59->00 increment in the same cycle.
module bcd_mod60_counter
  import clock_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens,
  output logic             wrap_c
);

  logic [BCD_W-1:0] r_ones;
  logic [BCD_W-1:0] r_tens;

  assign ones   = r_ones;
  assign tens   = r_tens;
  assign wrap_c = inc && !clr &&
                  (r_tens == BCD_W'(SEC_TENS_MAX)) && (r_ones == BCD_W'(ONES_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (clr) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (inc) begin
      if (r_ones == BCD_W'(ONES_MAX)) begin
        r_ones <= '0;
        r_tens <= (r_tens == BCD_W'(SEC_TENS_MAX)) ? '0 : r_tens + BCD_W'(1);
      end else begin
        r_ones <= r_ones + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// BCD time-of-day counter with 12h/24h hours and a RUN/SET_HR/SET_MIN set-time FSM.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter bit HOUR_24 = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               mode_btn,
  input  logic               inc_btn,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] hr_ones,
  output logic [DIGIT_W-1:0] hr_tens,
  output logic               pm,
  output logic               set_hr_active,
  output logic               set_min_active,
  output logic               day_pulse
);

  state_t           r_state;
  logic             r_set_hr;
  logic             r_set_min;
  logic             r_day;
  logic             r_pm;
  logic [BCD_W-1:0] r_hr_tens;
  logic [BCD_W-1:0] r_hr_ones;

  logic [BCD_W-1:0] w_hr_tens_nxt;
  logic [BCD_W-1:0] w_hr_ones_nxt;
  logic             w_pm_nxt;
  logic             w_midnight;
  logic             w_run_tick;
  logic             w_sec_clr;
  logic             w_min_inc;
  logic             w_hr_carry;
  logic             w_hr_inc;
  logic             w_sec_wrap;
  logic             w_min_wrap;
  logic [BCD_W-1:0] w_sec_ones;
  logic [BCD_W-1:0] w_sec_tens;
  logic [BCD_W-1:0] w_min_ones;
  logic [BCD_W-1:0] w_min_tens;

  // A mode press always wins, so ticks and increments are dropped on that cycle.
  assign w_run_tick = (r_state == RUN) && tick_1hz && !mode_btn;
  assign w_sec_clr  = (r_state == RUN) && mode_btn;
  assign w_min_inc  = (w_run_tick && w_sec_wrap) ||
                      ((r_state == SET_MIN) && inc_btn && !mode_btn);
  assign w_hr_carry = w_run_tick && w_sec_wrap && w_min_wrap;
  assign w_hr_inc   = w_hr_carry || ((r_state == SET_HR) && inc_btn && !mode_btn);

  bcd_mod60_counter u_sec (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_sec_clr),
    .inc    (w_run_tick),
    .ones   (w_sec_ones),
    .tens   (w_sec_tens),
    .wrap_c (w_sec_wrap)
  );

  bcd_mod60_counter u_min (
    .clk    (clk),
    .reset  (reset),
    .clr    (1'b0),
    .inc    (w_min_inc),
    .ones   (w_min_ones),
    .tens   (w_min_tens),
    .wrap_c (w_min_wrap)
  );

  // Next hour value; w_midnight marks the step that starts a new day.
  always_comb begin
    w_hr_tens_nxt = r_hr_tens;
    w_hr_ones_nxt = r_hr_ones + BCD_W'(1);
    w_pm_nxt      = r_pm;
    w_midnight    = 1'b0;
    if (HOUR_24) begin
      if ((r_hr_tens == BCD_W'(HR24_MAX / 10)) && (r_hr_ones == BCD_W'(HR24_MAX % 10))) begin
        w_hr_tens_nxt = '0;
        w_hr_ones_nxt = '0;
        w_midnight    = 1'b1;
      end else if (r_hr_ones == BCD_W'(ONES_MAX)) begin
        w_hr_tens_nxt = r_hr_tens + BCD_W'(1);
        w_hr_ones_nxt = '0;
      end
    end else begin
      if ((r_hr_tens == BCD_W'(1)) && (r_hr_ones == BCD_W'(2))) begin
        w_hr_tens_nxt = '0;
        w_hr_ones_nxt = BCD_W'(1);
      end else if ((r_hr_tens == BCD_W'(1)) && (r_hr_ones == BCD_W'(1))) begin
        w_pm_nxt   = !r_pm;
        w_midnight = r_pm;
      end else if (r_hr_ones == BCD_W'(ONES_MAX)) begin
        w_hr_tens_nxt = BCD_W'(1);
        w_hr_ones_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_set_hr  <= 1'b0;
      r_set_min <= 1'b0;
      r_day     <= 1'b0;
      r_pm      <= 1'b0;
      r_hr_tens <= HOUR_24 ? BCD_W'(0) : BCD_W'(1);
      r_hr_ones <= HOUR_24 ? BCD_W'(0) : BCD_W'(2);
    end else begin
      r_day <= w_hr_carry && w_midnight;
      if (w_hr_inc) begin
        r_hr_tens <= w_hr_tens_nxt;
        r_hr_ones <= w_hr_ones_nxt;
        r_pm      <= w_pm_nxt;
      end
      if (mode_btn) begin
        case (r_state)
          RUN: begin
            r_state   <= SET_HR;
            r_set_hr  <= 1'b1;
            r_set_min <= 1'b0;
          end
          SET_HR: begin
            r_state   <= SET_MIN;
            r_set_hr  <= 1'b0;
            r_set_min <= 1'b1;
          end
          default: begin
            r_state   <= RUN;
            r_set_hr  <= 1'b0;
            r_set_min <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sec_ones       = DIGIT_W'(w_sec_ones);
  assign sec_tens       = DIGIT_W'(w_sec_tens);
  assign min_ones       = DIGIT_W'(w_min_ones);
  assign min_tens       = DIGIT_W'(w_min_tens);
  assign hr_ones        = DIGIT_W'(r_hr_ones);
  assign hr_tens        = DIGIT_W'(r_hr_tens);
  assign pm             = r_pm;
  assign set_hr_active  = r_set_hr;
  assign set_min_active = r_set_min;
  assign day_pulse      = r_day;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: a 24h and a 12h instance share stimulus and one time-of-day model.
module tb_clock_time_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_1hz = 1'b0;
  logic mode_btn = 1'b0;
  logic inc_btn = 1'b0;

  logic [5:0] a_so, a_st, a_mo, a_mt, a_ho, a_ht;
  logic       a_pm, a_shr, a_smin, a_day;
  logic [5:0] b_so, b_st, b_mo, b_mt, b_ho, b_ht;
  logic       b_pm, b_shr, b_smin, b_day;

  int total = 0;
  int bad = 0;

  // Model: hours 0-23, minutes, seconds, mode 0=run 1=set hours 2=set minutes.
  int  mh, mm, ms, mmode;
  bit  mday;

  clock_time_counter #(.HOUR_24(1'b1)) dut24 (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
    .hr_ones(a_ho), .hr_tens(a_ht), .pm(a_pm), .set_hr_active(a_shr),
    .set_min_active(a_smin), .day_pulse(a_day)
  );

  clock_time_counter #(.HOUR_24(1'b0)) dut12 (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
    .hr_ones(b_ho), .hr_tens(b_ht), .pm(b_pm), .set_hr_active(b_shr),
    .set_min_active(b_smin), .day_pulse(b_day)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] expv(input bit h24, input int h, input int m, input int s,
                                       input bit shr, input bit smin, input bit day);
    int  hh;
    bit  p;
    if (h24) begin
      hh = h;
      p  = 1'b0;
    end else begin
      hh = (h % 12 == 0) ? 12 : h % 12;
      p  = (h >= 12);
    end
    return {6'(hh / 10), 6'(hh % 10), 6'(m / 10), 6'(m % 10), 6'(s / 10), 6'(s % 10),
            p, shr, smin, day};
  endfunction

  task automatic chk(input string name, input int h, input int m, input int s,
                     input bit shr, input bit smin, input bit day);
    logic [39:0] e24, e12, g24, g12;
    e24 = expv(1'b1, h, m, s, shr, smin, day);
    e12 = expv(1'b0, h, m, s, shr, smin, day);
    g24 = {a_ht, a_ho, a_mt, a_mo, a_st, a_so, a_pm, a_shr, a_smin, a_day};
    g12 = {b_ht, b_ho, b_mt, b_mo, b_st, b_so, b_pm, b_shr, b_smin, b_day};
    total += 2;
    if (g24 !== e24) begin
      bad++;
      $display("FAIL %s h24: got=%h want=%h (t=%0t)", name, g24, e24, $time);
    end
    if (g12 !== e12) begin
      bad++;
      $display("FAIL %s h12: got=%h want=%h (t=%0t)", name, g12, e12, $time);
    end
  endtask

  task automatic chk_model(input string name);
    chk(name, mh, mm, ms, mmode == 1, mmode == 2, mday);
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mmode = 0; mday = 1'b0;
  endtask

  // Seconds-of-day arithmetic for running time; set mode edits single fields.
  task automatic model_step(input bit t, input bit m, input bit i);
    int sod;
    mday = 1'b0;
    if (m) begin
      if (mmode == 0) ms = 0;
      mmode = (mmode + 1) % 3;
    end else if (mmode == 0 && t) begin
      sod  = mh * 3600 + mm * 60 + ms + 1;
      mday = (sod == 86400);
      sod  = sod % 86400;
      mh = sod / 3600; mm = (sod / 60) % 60; ms = sod % 60;
    end else if (mmode == 1 && i) begin
      mh = (mh + 1) % 24;
    end else if (mmode == 2 && i) begin
      mm = (mm + 1) % 60;
    end
  endtask

  task automatic step(input bit t, input bit m, input bit i);
    tick_1hz = t; mode_btn = m; inc_btn = i;
    @(posedge clk);
    model_step(t, m, i);
    #1;
    tick_1hz = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    chk_model("model");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick_1hz = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic repeat_step(input int n, input bit t, input bit m, input bit i);
    for (int k = 0; k < n; k++) step(t, m, i);
  endtask

  typedef struct {
    bit t, m, i;
    int h, mi, s;
    bit shr, smin;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 0, 0, 1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1, 0, 0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1, 1, 1, 1'b0, 1'b0};

    model_reset();
    do_reset();

    // Table vectors from reset.
    for (int v = 0; v < 10; v++) begin
      step(tbl[v].t, tbl[v].m, tbl[v].i);
      chk($sformatf("vec%0d", v), tbl[v].h, tbl[v].mi, tbl[v].s, tbl[v].shr, tbl[v].smin, 1'b0);
    end

    // Seconds carry into minutes.
    do_reset();
    repeat_step(59, 1'b1, 1'b0, 1'b0);
    chk("sec59", 0, 0, 59, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("min_carry", 0, 1, 0, 1'b0, 1'b0, 1'b0);

    // Preload 23:59, run into midnight.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    repeat_step(23, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(59, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("preload_2359", 23, 59, 0, 1'b0, 1'b0, 1'b0);
    repeat_step(59, 1'b1, 1'b0, 1'b0);
    chk("pre_midnight", 23, 59, 59, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("midnight", 0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("day_pulse_end", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // 12:59:59 AM -> 01:00:00, pm unchanged.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(59, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(59, 1'b1, 1'b0, 1'b0);
    chk("am_1259", 0, 59, 59, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("am_0100", 1, 0, 0, 1'b0, 1'b0, 1'b0);

    // Set-hours wrap, frozen time, mode beats inc, set-minutes wrap, resume.
    do_reset();
    repeat_step(5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("enter_set_hr", 0, 0, 0, 1'b1, 1'b0, 1'b0);
    repeat_step(25, 1'b0, 1'b0, 1'b1);
    chk("hr_inc25", 1, 0, 0, 1'b1, 1'b0, 1'b0);
    repeat_step(3, 1'b1, 1'b0, 1'b0);
    chk("set_hr_frozen", 1, 0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("mode_beats_inc", 1, 0, 0, 1'b0, 1'b1, 1'b0);
    repeat_step(59, 1'b0, 1'b0, 1'b1);
    chk("min59", 1, 59, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("min_wrap_nocarry", 1, 0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("back_to_run", 1, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("resume", 1, 0, 1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle from SET_MIN at 07:42.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    repeat_step(7, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(42, 1'b0, 1'b0, 1'b1);
    chk("at_0742", 7, 42, 0, 1'b0, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b0);
    chk("run_after_reset", 0, 0, 1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int r = 0; r < 3000; r++) begin
      step($urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0, $urandom_range(3, 0) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
